// File: rtl/tank_hit_tracker_if.sv
// Signal bundle between the two tank instances / keyboard and the hit tracker,
// plus the tracker's outputs toward the colour mapper and score display.
interface tank_hit_tracker_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] tankA_X, tankA_Y;
    logic [9:0] tankB_X, tankB_Y;
    logic [9:0] bulletA_X, bulletA_Y;
    logic [9:0] bulletB_X, bulletB_Y;
    logic [1:0] hitA, hitB;

    logic [1:0] livesA, livesB;
    logic [3:0] winsA, winsB;
    logic       flashA, flashB;
    logic       strikeA, strikeB;
    logic       game_over;
    logic [1:0] winner;

    // Producer side: tanks, keyboard; consumer of the tracker results.
    modport master (
        output frame_clk, keycode,
        output tankA_X, tankA_Y, tankB_X, tankB_Y,
        output bulletA_X, bulletA_Y, bulletB_X, bulletB_Y,
        output hitA, hitB,
        input  livesA, livesB, winsA, winsB, flashA, flashB,
        input  strikeA, strikeB, game_over, winner
    );

    // Tracker side.
    modport slave (
        input  frame_clk, keycode,
        input  tankA_X, tankA_Y, tankB_X, tankB_Y,
        input  bulletA_X, bulletA_Y, bulletB_X, bulletB_Y,
        input  hitA, hitB,
        output livesA, livesB, winsA, winsB, flashA, flashB,
        output strikeA, strikeB, game_over, winner
    );
endinterface

// File: rtl/tank_hit_tracker.sv
// Bullet-on-tank strike detection, lives / invulnerability / round-win
// bookkeeping and the PLAY/OVER round state machine. Everything advances
// once per rising edge of frame_clk; outputs are registered.
module tank_hit_tracker #(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned TANK_W        = 32,
    parameter int unsigned TANK_H        = 32,
    parameter int unsigned BUL_W         = 8,
    parameter int unsigned BUL_H         = 8,
    parameter logic [7:0]  RESTART_KEY   = 8'h15
) (
    input  logic             Clk,
    input  logic             Reset,
    tank_hit_tracker_if.slave bus
);
    localparam int CW = $clog2(INVULN_FRAMES + 1);

    typedef enum logic {PLAY, OVER} state_e;

    state_e        state_q;
    logic          frame_delayed_q, fe_q;
    logic [1:0]    lives_a_q, lives_b_q;
    logic [3:0]    wins_a_q, wins_b_q;
    logic [CW-1:0] cool_a_q, cool_b_q;
    logic          flash_a_q, flash_b_q;
    logic          strike_a_q, strike_b_q;
    logic          game_over_q;
    logic [1:0]    winner_q;

    logic          struck_a, struck_b, take_a, take_b;
    logic [CW-1:0] cool_a_d, cool_b_d;
    logic [1:0]    lives_a_d, lives_b_d;

    // Inclusive box overlap; sums widened to 11 bits so edges near 1023 never wrap.
    function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] tx, input logic [9:0] ty);
        return ({1'b0, bx} + 11'(BUL_W) >= {1'b0, tx}) &&
               ({1'b0, bx} <= {1'b0, tx} + 11'(TANK_W)) &&
               ({1'b0, by} + 11'(BUL_H) >= {1'b0, ty}) &&
               ({1'b0, by} <= {1'b0, ty} + 11'(TANK_H));
    endfunction

    // Per-player PLAY-frame step: strike test, cooldown countdown, life loss.
    // A tank is only ever struck by the opponent's bullet.
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        struck_a  = (bus.hitB == 2'b01) &&
                    overlap(bus.bulletB_X, bus.bulletB_Y, bus.tankA_X, bus.tankA_Y);
        struck_b  = (bus.hitA == 2'b01) &&
                    overlap(bus.bulletA_X, bus.bulletA_Y, bus.tankB_X, bus.tankB_Y);
        take_a    = struck_a && (cool_a_q == '0);
        take_b    = struck_b && (cool_b_q == '0);
        cool_a_d  = (cool_a_q != '0) ? cool_a_q - 1'b1 : (take_a ? CW'(INVULN_FRAMES) : '0);
        cool_b_d  = (cool_b_q != '0) ? cool_b_q - 1'b1 : (take_b ? CW'(INVULN_FRAMES) : '0);
        lives_a_d = take_a ? lives_a_q - 2'd1 : lives_a_q;
        lives_b_d = take_b ? lives_b_q - 2'd1 : lives_b_q;
    end

    // Frame-edge detect plus the round FSM with all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= PLAY;
            frame_delayed_q <= 1'b0;
            fe_q            <= 1'b0;
            lives_a_q       <= 2'(LIVES);
            lives_b_q       <= 2'(LIVES);
            wins_a_q        <= '0;
            wins_b_q        <= '0;
            cool_a_q        <= '0;
            cool_b_q        <= '0;
            flash_a_q       <= 1'b0;
            flash_b_q       <= 1'b0;
            strike_a_q      <= 1'b0;
            strike_b_q      <= 1'b0;
            game_over_q     <= 1'b0;
            winner_q        <= 2'b00;
        end else begin
            frame_delayed_q <= bus.frame_clk;
            fe_q            <= bus.frame_clk & ~frame_delayed_q;
            strike_a_q      <= 1'b0;
            strike_b_q      <= 1'b0;
            if (fe_q) begin
                case (state_q)
                    PLAY: begin
                        lives_a_q  <= lives_a_d;
                        lives_b_q  <= lives_b_d;
                        strike_a_q <= take_a;
                        strike_b_q <= take_b;
                        if (lives_a_d == '0 || lives_b_d == '0) begin
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                            cool_a_q    <= '0;
                            cool_b_q    <= '0;
                            flash_a_q   <= 1'b0;
                            flash_b_q   <= 1'b0;
                            if (lives_a_d == '0 && lives_b_d == '0) begin
                                winner_q <= 2'b11;
                            end else if (lives_a_d == '0) begin
                                winner_q <= 2'b10;
                                if (wins_b_q != 4'hF) wins_b_q <= wins_b_q + 4'd1;
                            end else begin
                                winner_q <= 2'b01;
                                if (wins_a_q != 4'hF) wins_a_q <= wins_a_q + 4'd1;
                            end
                        end else begin
                            cool_a_q  <= cool_a_d;
                            cool_b_q  <= cool_b_d;
                            flash_a_q <= (cool_a_d != '0);
                            flash_b_q <= (cool_b_d != '0);
                        end
                    end
                    OVER: begin
                        if (bus.keycode == RESTART_KEY) begin
                            state_q     <= PLAY;
                            lives_a_q   <= 2'(LIVES);
                            lives_b_q   <= 2'(LIVES);
                            winner_q    <= 2'b00;
                            game_over_q <= 1'b0;
                        end
                    end
                    default: state_q <= PLAY;
                endcase
            end
        end
    end

    assign bus.livesA    = lives_a_q;
    assign bus.livesB    = lives_b_q;
    assign bus.winsA     = wins_a_q;
    assign bus.winsB     = wins_b_q;
    assign bus.flashA    = flash_a_q;
    assign bus.flashB    = flash_b_q;
    assign bus.strikeA   = strike_a_q;
    assign bus.strikeB   = strike_b_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
endmodule

// File: doc/tank_hit_tracker.md
Name: tank_hit_tracker

Overview:
- Consumes position and bullet outputs of both tank instances (player A, player B); detects bullet-on-tank strikes once per frame.
- Tracks per-player lives, post-hit invulnerability and round wins; runs the round state machine (PLAY / OVER).
- Outputs drive the colour mapper (flash, game-over overlay) and score display.

Parameters:
- LIVES, 3, lives loaded at reset and at round restart (1..3)
- INVULN_FRAMES, 60, frames a struck tank ignores further strikes
- TANK_W, 32, tank box width (inclusive extent)
- TANK_H, 32, tank box height (inclusive extent)
- BUL_W, 8, bullet box width (inclusive extent)
- BUL_H, 8, bullet box height (inclusive extent)
- RESTART_KEY, 8'h15, keycode ('R') that starts a new round from OVER

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- frame_clk  in  1  ~60 Hz frame strobe; only its rising edge is used
- keycode  in  8  current USB keycode
- tankA_X, tankA_Y  in  10 each  player A tank top-left corner
- tankB_X, tankB_Y  in  10 each  player B tank top-left corner
- bulletA_X, bulletA_Y  in  10 each  player A bullet top-left corner
- bulletB_X, bulletB_Y  in  10 each  player B bullet top-left corner
- hitA, hitB  in  2 each  bullet status per tank (2'b01 = bullet in flight; any other value = no bullet)
- livesA, livesB  out  2 each  remaining lives
- winsA, winsB  out  4 each  rounds won, saturating at 15
- flashA, flashB  out  1 each  high while that tank is invulnerable
- strikeA, strikeB  out  1 each  one-Clk pulse when that tank loses a life
- game_over  out  1  high in OVER
- winner  out  2  00 none, 01 A, 10 B, 11 draw

Behaviour:
- Reset (async, Reset=0): state=PLAY, livesA=livesB=LIVES, winsA=winsB=0, cooldown counters=0, flash=0, strike=0, game_over=0, winner=00.
- Edge detect: frame_delayed<=frame_clk; fe<=frame_clk & ~frame_delayed. All updates below occur only on cycles with fe=1. Outputs change one Clk after fe.
- Overlap test, B struck by A's bullet (symmetric for A): hitA==2'b01 AND bulletA_X+BUL_W >= tankB_X AND bulletA_X <= tankB_X+TANK_W AND bulletA_Y+BUL_H >= tankB_Y AND bulletA_Y <= tankB_Y+TANK_H.
  - Sums are computed at 11 bits; no 10-bit wrap. Boundaries are inclusive.
- PLAY, per player P on fe:
  - If cooldownP>0: decrement cooldownP; ignore any strike on P.
  - Else if P is struck: livesP-1; cooldownP=INVULN_FRAMES; strikeP=1 for exactly one Clk.
  - flashP = (cooldownP != 0).
- Simultaneous strikes on A and B in the same frame are both applied.
- Transition to OVER on the fe where any lives reach 0:
  - Only A at 0: winner=10, winsB+1.
  - Only B at 0: winner=01, winsA+1.
  - Both at 0 together: winner=11; wins unchanged.
  - game_over=1. Cooldowns clear to 0; flash=0.
- OVER:
  - Strikes are ignored; lives hold.
  - On fe with keycode==RESTART_KEY: state=PLAY, lives reload to LIVES, winner=00, game_over=0. Wins are kept.
- Wins saturate at 15; no wrap.
- Lives never underflow: a strike with livesP==0 cannot occur, since OVER is entered first.
- Reset asserted mid-frame or mid-cooldown: immediate return to reset values; a pending fe is discarded.
- A tank's own bullet overlapping its own tank is never a strike.

Test Plan:
- Reset=0 then 1, no frames → livesA=livesB=3, wins=0, winner=00, game_over=0, flash=0.
- tankB=(100,100), bulletA=(132,120), hitA=01, one frame → livesB=2, strikeB one-Clk pulse one Clk after fe, flashB=1. Same with bulletA_X=133 → no strike.
- Hold the overlapping bullet for 60 frames → livesB stays 2 through cooldown; flashB drops after frame 60; next frame → livesB=1.
- hitA=10 with overlapping coordinates → no strike. bulletA overlapping tankA → no strike.
- Both bullets striking with livesA=livesB=1 on the same frame → game_over=1, winner=11, wins unchanged. keycode=8'h15 on the next frame → PLAY, lives=3, winner=00.
- A wins 16 rounds → winsA=15 saturated. Reset=0 during B cooldown → flashB=0, livesB=3 asynchronously, without waiting for a clock edge.
